// File: rtl/ledg_fader.sv
// Green-LED fader: turns the PIO's LED pattern into per-channel PWM drive.
// Each channel ramps its duty toward fully on or fully off on a slow fade tick.
module ledg_fader #(
  parameter int N_LEDS   = 9,
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_LEDS-1:0] led_pattern,
  input  logic              enable,
  input  logic              fade_bypass,
  output logic [N_LEDS-1:0] led_out,
  output logic              fade_busy
);

  localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_MIN = {PWM_BITS{1'b0}};
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [DIV_W-1:0]    div_cnt_r;
  logic                tick_s;
  logic [PWM_BITS-1:0] duty_r      [N_LEDS];
  logic [PWM_BITS-1:0] duty_next_s [N_LEDS];
  logic [N_LEDS-1:0]   led_next_s;
  logic                busy_next_s;

  assign tick_s = enable && (div_cnt_r == DIV_LAST);

  // PWM counter and fade-tick divider; both freeze while disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_r <= DUTY_MIN;
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (enable) begin
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
      div_cnt_r <= tick_s ? {DIV_W{1'b0}} : (div_cnt_r + DIV_W'(1));
    end else begin
      pwm_cnt_r <= pwm_cnt_r;
      div_cnt_r <= div_cnt_r;
    end
  end

  // Next duty per channel: bypass snaps, a tick steps one count toward the target
  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      duty_next_s[i] = duty_r[i];
      if (fade_bypass) begin
        duty_next_s[i] = led_pattern[i] ? DUTY_MAX : DUTY_MIN;
      end else if (tick_s) begin
        if (led_pattern[i] && (duty_r[i] != DUTY_MAX)) begin
          duty_next_s[i] = duty_r[i] + PWM_BITS'(1);
        end else if (!led_pattern[i] && (duty_r[i] != DUTY_MIN)) begin
          duty_next_s[i] = duty_r[i] - PWM_BITS'(1);
        end else begin
          duty_next_s[i] = duty_r[i];
        end
      end else begin
        duty_next_s[i] = duty_r[i];
      end
    end
  end

  // Duty registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_LEDS; i++) begin
      if (reset) begin
        duty_r[i] <= DUTY_MIN;
      end else begin
        duty_r[i] <= duty_next_s[i];
      end
    end
  end

  // PWM compare and busy detect; busy is masked in bypass since duty lands on target in one edge
  always_comb begin
    led_next_s  = {N_LEDS{1'b0}};
    busy_next_s = 1'b0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (!enable) begin
        led_next_s[i] = 1'b0;
      end else if (duty_r[i] == DUTY_MAX) begin
        led_next_s[i] = 1'b1;
      end else begin
        led_next_s[i] = (duty_r[i] > pwm_cnt_r);
      end
      busy_next_s = busy_next_s |
        (!fade_bypass && (duty_r[i] != (led_pattern[i] ? DUTY_MAX : DUTY_MIN)));
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      led_out   <= {N_LEDS{1'b0}};
      fade_busy <= 1'b0;
    end else begin
      led_out   <= led_next_s;
      fade_busy <= busy_next_s;
    end
  end

endmodule

// File: tb/tb_ledg_fader.sv
// Directed bench for ledg_fader with FADE_DIV=4: vector table for reset/bypass/enable,
// closed-form fade model for the multi-cycle ramp, reversal and mid-fade sequences.
module tb_ledg_fader;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] led_pattern;
  logic       enable;
  logic       fade_bypass;
  logic [8:0] led_out;
  logic       fade_busy;

  int total = 0;
  int bad   = 0;

  ledg_fader #(.N_LEDS(9), .PWM_BITS(8), .FADE_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .led_pattern (led_pattern),
    .enable      (enable),
    .fade_bypass (fade_bypass),
    .led_out     (led_out),
    .fade_busy   (fade_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       byp;
    logic [8:0] pat;
    logic [8:0] exp_led;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at step %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; fade_bypass = 1'b0; led_pattern = 9'h000;
    step();
    reset = 1'b0;
  endtask

  // Duty after enabled edge n since reset when pattern bit 0 is 1 for edges 1..up, then 0.
  function automatic int exp_duty(input int n, input int up);
    int d_up;
    int d;
    if (n <= up) begin
      d = n / 4;
      return (d > 255) ? 255 : d;
    end
    d_up = (up / 4 > 255) ? 255 : up / 4;
    d = d_up - (n / 4 - up / 4);
    return (d < 0) ? 0 : d;
  endfunction

  // Runs edges 1..total_edges right after a reset edge, checking duty, led_out and fade_busy.
  task automatic run_fade(input string name, input int up, input int total_edges);
    int d_prev;
    int p_prev;
    logic exp_led0;
    logic exp_busy;
    logic pat_now;
    for (int n = 1; n <= total_edges; n++) begin
      pat_now = (n <= up);
      led_pattern = {8'h00, pat_now};
      enable = 1'b1; fade_bypass = 1'b0; reset = 1'b0;
      step();
      d_prev = exp_duty(n - 1, up);
      p_prev = (n - 1) % 256;
      exp_led0 = (d_prev == 255) || (d_prev > p_prev);
      exp_busy = pat_now ? (d_prev != 255) : (d_prev != 0);
      chk({name, "_duty"}, n, 32'(dut.duty_r[0]), 32'(exp_duty(n, up)));
      chk({name, "_led"},  n, 32'(led_out), {23'd0, 8'h00, exp_led0});
      chk({name, "_busy"}, n, 32'(fade_busy), {31'd0, exp_busy});
    end
  endtask

  initial begin
    //          rst   en    byp   pat     exp_led exp_busy
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 9'h1FF, 9'h000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 9'h1FF, 9'h000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 9'h1FF, 9'h000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 9'h1FF, 9'h1FF, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 9'h155, 9'h1FF, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 9'h155, 9'h155, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 9'h155, 9'h155, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 9'h155, 9'h000, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 9'h155, 9'h155, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 9'h155, 9'h000, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0};

    reset = 1'b1; enable = 1'b0; fade_bypass = 1'b0; led_pattern = 9'h000;
    #1;

    for (int v = 0; v < 11; v++) begin
      reset = vecs[v].rst; enable = vecs[v].en;
      fade_bypass = vecs[v].byp; led_pattern = vecs[v].pat;
      step();
      chk("vec_led",  v, 32'(led_out),   32'(vecs[v].exp_led));
      chk("vec_busy", v, 32'(fade_busy), 32'(vecs[v].exp_busy));
      if (vecs[v].rst) begin
        for (int i = 0; i < 9; i++) chk("vec_rst_duty", v, 32'(dut.duty_r[i]), 32'd0);
      end
    end

    // Full fade up, saturation at 255 and steady-on afterwards
    do_reset();
    run_fade("fade_up", 100000, 1100);

    // Reversal at duty 100, ramp down to 0 without wrapping
    do_reset();
    run_fade("reverse", 400, 900);

    // Disable mid-fade, then reset, then restart from 0
    do_reset();
    run_fade("pre_dis", 100000, 40);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("dis_led",  k, 32'(led_out),         32'd0);
      chk("dis_busy", k, 32'(fade_busy),       32'd1);
      chk("dis_duty", k, 32'(dut.duty_r[0]),   32'd10);
    end
    reset = 1'b1;
    step();
    chk("mid_rst_duty", 0, 32'(dut.duty_r[0]), 32'd0);
    chk("mid_rst_busy", 0, 32'(fade_busy),     32'd0);
    chk("mid_rst_led",  0, 32'(led_out),       32'd0);
    run_fade("restart", 100000, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
